// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared payload type and counter width for the writeback arbiter
package regfile_wb_arbiter_pkg;
  localparam int CNT_W = 16;
  localparam int WB_ADDR_W = 6;
  localparam int WB_DATA_W = 32;
  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_payload_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant searching upward from ptr with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  int j;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    j = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        gnt[j] = 1'b1;
        idx = IW'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbitration of writeback requesters onto one regfile write port with forwarding
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int FWD_PORTS = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [N_REQ-1:0]                      req_valid_i,
  input  logic [N_REQ-1:0][ADDR_DEPTH-1:0]      req_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_data_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  output logic                                  rf_we_o,
  output logic [ADDR_DEPTH-1:0]                 rf_waddr_o,
  output logic [DATA_WIDTH-1:0]                 rf_wdata_o,
  input  logic [FWD_PORTS-1:0][ADDR_DEPTH-1:0]  fwd_raddr_i,
  output logic [FWD_PORTS-1:0]                  fwd_hit_o,
  output logic [FWD_PORTS-1:0][DATA_WIDTH-1:0]  fwd_data_o,
  output logic [CNT_W-1:0]                      conflict_cnt_o
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  logic [IW-1:0] rr_ptr, gidx, nxt_ptr;
  logic [N_REQ-1:0] gnt;
  logic xfer, multi;
  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req(req_valid_i),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(gidx)
  );
  assign req_ready_o = rst ? '0 : gnt;
  assign xfer = |req_ready_o;
  assign multi = |(req_valid_i & (req_valid_i - N_REQ'(1)));
  assign nxt_ptr = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      rf_we_o <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      conflict_cnt_o <= '0;
    end else begin
      rf_we_o <= xfer;
      if (xfer) begin
        rr_ptr <= nxt_ptr;
        rf_waddr_o <= req_addr_i[gidx];
        rf_wdata_o <= req_data_i[gidx];
      end
      if (multi && conflict_cnt_o != '1) conflict_cnt_o <= conflict_cnt_o + CNT_W'(1);
    end
  end
  always_comb begin
    fwd_hit_o = '0;
    fwd_data_o = '0;
    for (int k = 0; k < FWD_PORTS; k++) begin
      fwd_hit_o[k] = rf_we_o && (fwd_raddr_i[k] == rf_waddr_o);
      fwd_data_o[k] = fwd_hit_o[k] ? rf_wdata_o : '0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the writeback arbiter
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid;
  logic [3:0][5:0] req_addr;
  logic [3:0][31:0] req_data;
  logic [3:0] req_ready;
  logic rf_we;
  logic [5:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0][5:0] fwd_raddr;
  logic [1:0] fwd_hit;
  logic [1:0][31:0] fwd_data;
  logic [15:0] cnt;
  logic [31:0] mem [64];
  wb_payload_t exp_q [$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  regfile_wb_arbiter dut (
    .clk(clk),
    .rst(rst),
    .req_valid_i(req_valid),
    .req_addr_i(req_addr),
    .req_data_i(req_data),
    .req_ready_o(req_ready),
    .rf_we_o(rf_we),
    .rf_waddr_o(rf_waddr),
    .rf_wdata_o(rf_wdata),
    .fwd_raddr_i(fwd_raddr),
    .fwd_hit_o(fwd_hit),
    .fwd_data_o(fwd_data),
    .conflict_cnt_o(cnt)
  );
  always @(posedge clk) if (!rst && rf_we) mem[rf_waddr] <= rf_wdata;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [5:0] a, input logic [31:0] d);
    wb_payload_t p;
    p.addr = a;
    p.data = d;
    exp_q.push_back(p);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got addr %0h data %0h expected no write", rf_waddr, rf_wdata);
      end else begin
        wb_payload_t p;
        p = exp_q.pop_front();
        check("wr_addr", 64'(rf_waddr), 64'(p.addr));
        check("wr_data", 64'(rf_wdata), 64'(p.data));
      end
    end
  end
  initial begin
    logic g;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1'b1;
    req_valid = 4'b1111;
    req_addr = '0;
    req_data = '0;
    fwd_raddr = '0;
    tick;
    tick;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'h0);
    check("rst_we", 64'(rf_we), 64'h0);
    check("rst_waddr", 64'(rf_waddr), 64'h0);
    check("rst_wdata", 64'(rf_wdata), 64'h0);
    check("rst_cnt", 64'(cnt), 64'h0);
    tick;
    rst = 1'b0;
    req_valid = 4'b0000;
    tick;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 6'(i + 1);
      req_data[i] = 32'h100 + 32'(i);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << c));
      push(6'(c + 1), 32'h100 + 32'(c));
      tick;
    end
    req_valid = 4'b0000;
    @(negedge clk);
    check("cnt_four", 64'(cnt), 64'd4);
    tick;
    req_valid = 4'b0100;
    req_addr[2] = 6'd5;
    req_data[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    check("solo_ready", 64'(req_ready), 64'h4);
    push(6'd5, 32'hDEAD_BEEF);
    tick;
    req_valid = 4'b0000;
    fwd_raddr[0] = 6'd5;
    fwd_raddr[1] = 6'd6;
    @(negedge clk);
    check("fwd_hit", 64'(fwd_hit), 64'h1);
    check("fwd_data0", 64'(fwd_data[0]), 64'hDEAD_BEEF);
    check("fwd_data1", 64'(fwd_data[1]), 64'h0);
    tick;
    @(negedge clk);
    check("fwd_hit_after", 64'(fwd_hit), 64'h0);
    check("fwd_data_after", 64'(fwd_data[0]), 64'h0);
    tick;
    req_valid = 4'b1000;
    req_addr[3] = 6'd9;
    req_data[3] = 32'h33;
    @(negedge clk);
    check("ptr_align", 64'(req_ready), 64'h8);
    push(6'd9, 32'h33);
    tick;
    req_valid = 4'b1001;
    req_addr[0] = 6'd7;
    req_data[0] = 32'd1;
    req_addr[3] = 6'd7;
    req_data[3] = 32'd2;
    @(negedge clk);
    check("same_addr_first", 64'(req_ready), 64'h1);
    push(6'd7, 32'd1);
    tick;
    req_valid = 4'b1000;
    @(negedge clk);
    check("same_addr_second", 64'(req_ready), 64'h8);
    push(6'd7, 32'd2);
    tick;
    req_valid = 4'b0000;
    tick;
    tick;
    @(negedge clk);
    check("rf_last_wins", 64'(mem[7]), 64'd2);
    check("cnt_five", 64'(cnt), 64'd5);
    for (int c = 0; c < 3; c++) begin
      tick;
      @(negedge clk);
      check("idle_we", 64'(rf_we), 64'h0);
      check("idle_waddr", 64'(rf_waddr), 64'd7);
      check("idle_wdata", 64'(rf_wdata), 64'd2);
    end
    tick;
    req_valid = 4'b1111;
    req_addr[0] = 6'd10;
    req_data[0] = 32'hA0;
    @(negedge clk);
    check("idle_ptr_held", 64'(req_ready), 64'h1);
    push(6'd10, 32'hA0);
    tick;
    req_valid = 4'b0010;
    req_addr[1] = 6'd11;
    req_data[1] = 32'hB1;
    @(negedge clk);
    check("pre_rst_grant", 64'(req_ready), 64'h2);
    push(6'd11, 32'hB1);
    tick;
    rst = 1'b1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("rst_ready_forced", 64'(req_ready), 64'h0);
    check("inflight_we", 64'(rf_we), 64'h1);
    tick;
    rst = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    check("post_rst_we", 64'(rf_we), 64'h0);
    check("post_rst_cnt", 64'(cnt), 64'h0);
    check("post_rst_waddr", 64'(rf_waddr), 64'h0);
    check("discarded_write", 64'(mem[11]), 64'h0);
    tick;
    req_valid = 4'b1101;
    req_addr[0] = 6'd12;
    req_data[0] = 32'hC0;
    @(negedge clk);
    check("post_rst_ptr", 64'(req_ready), 64'h1);
    push(6'd12, 32'hC0);
    tick;
    req_valid = 4'b0011;
    req_addr[0] = 6'd20;
    req_data[0] = 32'h20;
    req_addr[1] = 6'd21;
    req_data[1] = 32'h21;
    g = 1'b1;
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      check("sat_grant", 64'(req_ready), g ? 64'h2 : 64'h1);
      push(g ? 6'd21 : 6'd20, g ? 32'h21 : 32'h20);
      tick;
      g = ~g;
    end
    @(negedge clk);
    check("cnt_sat", 64'(cnt), 64'hFFFF);
    push(g ? 6'd21 : 6'd20, g ? 32'h21 : 32'h20);
    tick;
    req_valid = 4'b0000;
    @(negedge clk);
    check("cnt_sat_hold", 64'(cnt), 64'hFFFF);
    tick;
    tick;
    @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
